// File: rtl/wavefront_pop_scheduler_pkg.sv
// Shared definitions for the wavefront pop scheduler.
//   IB_BANK_W       : number of physical input-buffer column FIFOs
//   wps_state_t     : scheduler FSM state encoding
//   wps_cfg_legal() : frame configuration legality check
// Optional feature macro used by the scheduler: WPS_STALL_CNT_EN
package wavefront_pop_scheduler_pkg;

    localparam int unsigned IB_BANK_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT_IB,
        ST_WAVE,
        ST_SHIFT
    } wps_state_t;

    // Legal when 1 <= K <= H and 1 <= W <= bank width.
    function automatic logic wps_cfg_legal(
        input logic [31:0] w,
        input logic [31:0] h,
        input logic [3:0]  k,
        input logic [31:0] bank_w
    );
        logic [31:0] k_ext;
        k_ext = {28'd0, k};
        return (k_ext != '0) && (k_ext <= h) && (w != '0) && (w <= bank_w);
    endfunction

endpackage

// File: rtl/wavefront_pop_scheduler_skew_gen.sv
// wps_skew_gen: diagonal pop mask for one wave.
//   t_i   : wave cycle counter
//   k_i   : kernel rows K (>= 1)
//   w_i   : active columns W
//   pop_o : column c pops when c < W and c <= t <= c+K-1
// Equivalent to a shift register fed K ones at column 0 and shifting one
// column per cycle, truncated at column W.
module wps_skew_gen
    import wavefront_pop_scheduler_pkg::*;
#(
    parameter int unsigned BANK_WIDTH = IB_BANK_W,
    parameter int unsigned CNT_W      = 32
) (
    input  logic [CNT_W-1:0]      t_i,
    input  logic [3:0]            k_i,
    input  logic [CNT_W-1:0]      w_i,
    output logic [BANK_WIDTH-1:0] pop_o
);

    always_comb begin
        pop_o = '0;
        for (int unsigned c = 0; c < BANK_WIDTH; c++) begin
            pop_o[c] = (CNT_W'(c) < w_i) &&
                       (t_i >= CNT_W'(c)) &&
                       (t_i <= CNT_W'(c) + CNT_W'(k_i) - CNT_W'(1));
        end
    end

endmodule

// File: rtl/wavefront_pop_scheduler.sv
// wavefront_pop_scheduler: drives skewed per-column pops into the input
// buffer, one wave of W+K-1 cycles per output row, H-K+1 rows per frame.
// Ports:
//   clk_i, rst_sync_i        : clock, synchronous active-high reset
//   start_i                  : frame start pulse (only honoured in IDLE)
//   cfg_img_w_i/h_i/kernel_r : frame config, latched on an accepted start
//   ib_ready_i               : input buffer holds K valid rows
//   pop_o                    : per-column pop mask
//   pre_wave_done_o          : row finished, shift the window
//   sa_done_o                : frame finished
//   busy_o, cfg_err_o        : not idle / sticky illegal-config flag
//   row_idx_o                : current output row
//   stall_cnt_o              : WAIT_IB stall cycles (WPS_STALL_CNT_EN only)
// Macro: WPS_STALL_CNT_EN adds the stall counter.
module wavefront_pop_scheduler
    import wavefront_pop_scheduler_pkg::*;
#(
    parameter int unsigned BANK_WIDTH = IB_BANK_W,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_sync_i,
    input  logic                  start_i,
    input  logic [31:0]           cfg_img_w_i,
    input  logic [31:0]           cfg_img_h_i,
    input  logic [3:0]            cfg_kernel_r_i,
    input  logic                  ib_ready_i,
    output logic [BANK_WIDTH-1:0] pop_o,
    output logic                  pre_wave_done_o,
    output logic                  sa_done_o,
    output logic                  busy_o,
    output logic                  cfg_err_o,
    output logic [CNT_W-1:0]      row_idx_o
`ifdef WPS_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0]      stall_cnt_o
`endif
);

    wps_state_t state_q, state_nxt;

    logic [31:0]           w_q;
    logic [31:0]           h_q;
    logic [3:0]            k_q;
    logic [CNT_W-1:0]      t_q;
    logic [CNT_W-1:0]      row_idx_q;
    logic                  cfg_err_q;
    logic                  cfg_ok;
    logic                  start_accept;
    logic [CNT_W-1:0]      wave_last;
    logic [CNT_W-1:0]      last_row;
    logic                  is_last_row;
    logic [BANK_WIDTH-1:0] skew_mask;

    assign cfg_ok       = wps_cfg_legal(cfg_img_w_i, cfg_img_h_i, cfg_kernel_r_i, 32'(BANK_WIDTH));
    assign start_accept = (state_q == ST_IDLE) && start_i && cfg_ok;
    // Last wave cycle index W+K-2; W,K >= 1 once latched, so no underflow.
    assign wave_last    = CNT_W'(w_q) + CNT_W'(k_q) - CNT_W'(2);
    assign last_row     = CNT_W'(h_q) - CNT_W'(k_q);
    assign is_last_row  = (row_idx_q == last_row);

    wps_skew_gen #(
        .BANK_WIDTH (BANK_WIDTH),
        .CNT_W      (CNT_W)
    ) u_skew_gen (
        .t_i   (t_q),
        .k_i   (k_q),
        .w_i   (CNT_W'(w_q)),
        .pop_o (skew_mask)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:    if (start_accept)        state_nxt = ST_WAIT_IB;
            ST_WAIT_IB: if (ib_ready_i)          state_nxt = ST_WAVE;
            ST_WAVE:    if (t_q == wave_last)    state_nxt = ST_SHIFT;
            ST_SHIFT:   state_nxt = is_last_row ? ST_IDLE : ST_WAIT_IB;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Outputs decoded from the current state so reset silences them at the edge.
    always_comb begin
        pop_o           = '0;
        pre_wave_done_o = 1'b0;
        sa_done_o       = 1'b0;
        busy_o          = (state_q != ST_IDLE);
        if (state_q == ST_WAVE) begin
            pop_o = skew_mask;
        end
        if (state_q == ST_SHIFT) begin
            pre_wave_done_o = !is_last_row;
            sa_done_o       = is_last_row;
        end
    end

    // Config latch, wave and row counters, error flag
    always_ff @(posedge clk_i) begin
        if (rst_sync_i) begin
            w_q       <= '0;
            h_q       <= '0;
            k_q       <= '0;
            t_q       <= '0;
            row_idx_q <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (start_accept) begin
                w_q       <= cfg_img_w_i;
                h_q       <= cfg_img_h_i;
                k_q       <= cfg_kernel_r_i;
                row_idx_q <= '0;
                cfg_err_q <= 1'b0;
            end else if ((state_q == ST_IDLE) && start_i) begin
                cfg_err_q <= 1'b1;
            end

            // t is held at zero while waiting so the wave starts at t=0.
            if (state_q == ST_WAVE) begin
                t_q <= t_q + CNT_W'(1);
            end else begin
                t_q <= '0;
            end

            if ((state_q == ST_SHIFT) && !is_last_row) begin
                row_idx_q <= row_idx_q + CNT_W'(1);
            end
        end
    end

    assign cfg_err_o = cfg_err_q;
    assign row_idx_o = row_idx_q;

`ifdef WPS_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;

    // Counts WAIT_IB cycles where the buffer is not yet ready; saturating.
    always_ff @(posedge clk_i) begin
        if (rst_sync_i || start_accept) begin
            stall_cnt_q <= '0;
        end else if ((state_q == ST_WAIT_IB) && !ib_ready_i && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_wavefront_pop_scheduler.sv
module tb_wavefront_pop_scheduler;

    logic        clk_i = 1'b0;
    logic        rst_sync_i;
    logic        start_i;
    logic [31:0] cfg_img_w_i;
    logic [31:0] cfg_img_h_i;
    logic [3:0]  cfg_kernel_r_i;
    logic        ib_ready_i;
    logic [31:0] pop_o;
    logic        pre_wave_done_o;
    logic        sa_done_o;
    logic        busy_o;
    logic        cfg_err_o;
    logic [31:0] row_idx_o;
`ifdef WPS_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    wavefront_pop_scheduler #(
        .BANK_WIDTH (32),
        .CNT_W      (32)
    ) dut (
        .clk_i           (clk_i),
        .rst_sync_i      (rst_sync_i),
        .start_i         (start_i),
        .cfg_img_w_i     (cfg_img_w_i),
        .cfg_img_h_i     (cfg_img_h_i),
        .cfg_kernel_r_i  (cfg_kernel_r_i),
        .ib_ready_i      (ib_ready_i),
        .pop_o           (pop_o),
        .pre_wave_done_o (pre_wave_done_o),
        .sa_done_o       (sa_done_o),
        .busy_o          (busy_o),
        .cfg_err_o       (cfg_err_o),
        .row_idx_o       (row_idx_o)
`ifdef WPS_STALL_CNT_EN
        ,
        .stall_cnt_o     (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [31:0] wave0 [6];
        int          pre_cnt;
        wave0[0] = 32'h1; wave0[1] = 32'h3; wave0[2] = 32'h7;
        wave0[3] = 32'he; wave0[4] = 32'hc; wave0[5] = 32'h8;

        // Reset
        rst_sync_i = 1'b1; start_i = 1'b0; ib_ready_i = 1'b0;
        cfg_img_w_i = 32'd4; cfg_img_h_i = 32'd6; cfg_kernel_r_i = 4'd3;
        tick(); tick();
        chk("rst_pop", pop_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_err", cfg_err_o, 0);
        chk("rst_row", row_idx_o, 0);
        chk("rst_pre", pre_wave_done_o, 0);
        chk("rst_sa", sa_done_o, 0);

        // W=4 H=6 K=3, ready held high: 4 waves of 6 cycles
        rst_sync_i = 1'b0; ib_ready_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        // Config changes after acceptance must not affect the frame
        cfg_img_w_i = 32'd1; cfg_img_h_i = 32'd1; cfg_kernel_r_i = 4'd1;
        chk("f1_busy", busy_o, 1);
        chk("f1_wait_pop", pop_o, 0);
        for (int r = 0; r < 4; r++) begin
            tick();
            for (int i = 0; i < 6; i++) begin
                chk($sformatf("f1_r%0d_pop%0d", r, i), pop_o, wave0[i]);
                if (i < 5) tick();
            end
            tick();
            chk($sformatf("f1_r%0d_shift_pop", r), pop_o, 0);
            chk($sformatf("f1_r%0d_pre", r), pre_wave_done_o, (r < 3) ? 1 : 0);
            chk($sformatf("f1_r%0d_sa", r), sa_done_o, (r == 3) ? 1 : 0);
            chk($sformatf("f1_r%0d_row", r), row_idx_o, r);
            tick();
            chk($sformatf("f1_r%0d_busy_after", r), busy_o, (r < 3) ? 1 : 0);
            chk($sformatf("f1_r%0d_pop_after", r), pop_o, 0);
        end
        chk("f1_row_end", row_idx_o, 3);

        // Ready low for 10 cycles: W=2 H=1 K=1
        cfg_img_w_i = 32'd2; cfg_img_h_i = 32'd1; cfg_kernel_r_i = 4'd1;
        ib_ready_i = 1'b0; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("stall_pop%0d", i), pop_o, 0);
            chk($sformatf("stall_busy%0d", i), busy_o, 1);
        end
        ib_ready_i = 1'b1;
        tick();
        chk("stall_first_pop", pop_o, 32'h1);
`ifdef WPS_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o, 10);
`endif
        ib_ready_i = 1'b0;  // must not stall the running wave
        tick();
        chk("stall_pop_t1", pop_o, 32'h2);
        tick();
        chk("stall_sa", sa_done_o, 1);
        chk("stall_pre", pre_wave_done_o, 0);
        tick();
        chk("stall_idle", busy_o, 0);

        // Illegal config K=5 > H=4
        cfg_img_w_i = 32'd4; cfg_img_h_i = 32'd4; cfg_kernel_r_i = 4'd5;
        ib_ready_i = 1'b1; start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("bad_err", cfg_err_o, 1);
        chk("bad_busy", busy_o, 0);
        chk("bad_pop", pop_o, 0);
        tick();
        chk("bad_err_sticky", cfg_err_o, 1);
        chk("bad_busy2", busy_o, 0);
        chk("bad_pop2", pop_o, 0);

        // W=H=K=1 legal start clears the error; repeated starts are ignored
        cfg_img_w_i = 32'd1; cfg_img_h_i = 32'd1; cfg_kernel_r_i = 4'd1;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        chk("one_err_clr", cfg_err_o, 0);
        chk("one_busy", busy_o, 1);
        tick();
        chk("one_pop", pop_o, 32'h1);
        start_i = 1'b1;
        tick();
        chk("one_sa", sa_done_o, 1);
        chk("one_pre", pre_wave_done_o, 0);
        chk("one_shift_pop", pop_o, 0);
        tick();
        start_i = 1'b0;
        chk("one_idle", busy_o, 0);
        tick();
        chk("one_still_idle", busy_o, 0);

        // Reset at t=2 of a W=28 K=5 wave
        cfg_img_w_i = 32'd28; cfg_img_h_i = 32'd10; cfg_kernel_r_i = 4'd5;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick();
        chk("rw_t0", pop_o, 32'h1);
        tick();
        chk("rw_t1", pop_o, 32'h3);
        tick();
        chk("rw_t2", pop_o, 32'h7);
        rst_sync_i = 1'b1;
        tick();
        chk("rw_rst_pop", pop_o, 0);
        chk("rw_rst_busy", busy_o, 0);
        chk("rw_rst_row", row_idx_o, 0);
        chk("rw_rst_pre", pre_wave_done_o, 0);
        rst_sync_i = 1'b0;
        pre_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (pre_wave_done_o || sa_done_o || (pop_o != 0) || busy_o) pre_cnt++;
        end
        chk("rw_quiet_after", pre_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global time limit so the bench never hangs
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/wavefront_pop_scheduler.md
WAVEFRONT_POP_SCHEDULER -- requirements
Module: wavefront_pop_scheduler

Interface
REQ-001 SHALL have parameter BANK_WIDTH, default IB_BANK_W: number of physical column FIFOs driven.
REQ-002 SHALL have parameter CNT_W, default 32: width of row and cycle counters.
REQ-003 SHALL have ports: clk_i  in  1  sole clock; all logic on its rising edge.
REQ-004 SHALL have ports: rst_sync_i  in  1  reset; synchronous and active-high.
REQ-005 SHALL have ports: start_i  in  1  one-cycle start pulse for a frame.
REQ-006 SHALL have ports: cfg_img_w_i  in  32  image width W.
REQ-007 SHALL have ports: cfg_img_h_i  in  32  image height H.
REQ-008 SHALL have ports: cfg_kernel_r_i  in  4  kernel rows K.
REQ-009 SHALL have ports: ib_ready_i  in  1  the input buffer holds K valid rows.
REQ-010 SHALL have ports: pop_o  out  BANK_WIDTH  per-column skewed pop to the input buffer.
REQ-011 SHALL have ports: pre_wave_done_o  out  1  one-cycle pulse: top row consumed; shift the window.
REQ-012 SHALL have ports: sa_done_o  out  1  one-cycle pulse: frame complete; drives the input buffer sa_done.
REQ-013 SHALL have ports: busy_o  out  1  high whenever state is not IDLE.
REQ-014 SHALL have ports: cfg_err_o  out  1  sticky flag: start was rejected for an illegal config.
REQ-015 SHALL have ports: row_idx_o  out  CNT_W  index of the current output row, 0..H-K.

Function
REQ-016 SHALL implement states IDLE, WAIT_IB, WAVE, SHIFT.
REQ-017 IDLE->WAIT_IB SHALL occur when start_i is high and the config is legal: 1<=K, K<=H, 1<=W<=BANK_WIDTH.
- An illegal config SHALL set cfg_err_o and the block SHALL stay in IDLE.
- A legal start SHALL clear cfg_err_o.
REQ-018 start_i SHALL be ignored outside IDLE.
REQ-019 WAIT_IB->WAVE SHALL occur on the first cycle ib_ready_i is sampled high.
- The wave cycle counter t SHALL be cleared to 0 on this transition.
REQ-020 During WAVE, pop_o[c] SHALL be high exactly when c < W and c <= t <= c+K-1.
- This gives a diagonal skew of one column per cycle.
- The first pop (column 0) SHALL occur in the first WAVE cycle.
REQ-021 WAVE SHALL last exactly W+K-1 cycles, t = 0..W+K-2.
REQ-022 pop_o SHALL be all-zero outside WAVE.
REQ-023 ib_ready_i SHALL be sampled only in WAIT_IB; deassertion during WAVE SHALL NOT stall or abort the wave.
REQ-024 After the last WAVE cycle the block SHALL enter SHIFT for one cycle.
- If row_idx_o < H-K: pre_wave_done_o SHALL pulse, row_idx_o SHALL increment, and next state SHALL be WAIT_IB.
- If row_idx_o == H-K: sa_done_o SHALL pulse, pre_wave_done_o SHALL stay low, and next state SHALL be IDLE.
REQ-025 pre_wave_done_o and sa_done_o SHALL never be high in the same cycle.
REQ-026 Config inputs SHALL be latched on the accepted start; later changes SHALL have no effect until the next frame.
REQ-027 Counter compares SHALL be evaluated at CNT_W bits, with K zero-extended.
- W+K-1 SHALL NOT overflow for W <= BANK_WIDTH.
REQ-028 K == H SHALL produce exactly one wave followed directly by sa_done_o.

Reset
REQ-029 When rst_sync_i is high at a clock edge:
- state SHALL go to IDLE;
- pop_o, pre_wave_done_o, sa_done_o, busy_o, and cfg_err_o SHALL be 0;
- row_idx_o and t SHALL be 0.
REQ-030 Reset asserted mid-WAVE SHALL zero pop_o at that edge, with no trailing pulses.

Configuration
REQ-031 With WPS_STALL_CNT_EN defined:
- an extra output stall_cnt_o (out, CNT_W) SHALL count cycles spent in WAIT_IB;
- the count SHALL clear on an accepted start and saturate at its maximum.
- Without WPS_STALL_CNT_EN: no port and no logic.

Structure
REQ-032 The state enum typedef SHALL reside in the shared definitions package; IB_BANK_W SHALL come from that package.
REQ-033 The diagonal skew generation SHALL be a sub-module wps_skew_gen.
- Inputs: t, K, W.
- Output: pop mask.
- It SHALL be realisable as a shift register fed with K ones.

Verification
REQ-034 W=4, H=6, K=3, ib_ready_i held high: exactly 4 waves of 6 cycles each.
- In wave 0: pop_o = 0001, 0011, 0111, 1110, 1100, 1000.
- pre_wave_done_o pulses 3 times, then sa_done_o pulses once; row_idx_o ends at 3.
REQ-035 ib_ready_i low for 10 cycles after start: no pops, block remains in WAIT_IB.
- With WPS_STALL_CNT_EN, stall_cnt_o == 10; the first pop occurs the cycle after ready is seen.
REQ-036 start_i with K=5, H=4: cfg_err_o=1, busy_o stays 0, no pops.
- A subsequent legal start clears cfg_err_o.
REQ-037 rst_sync_i asserted at t=2 of a W=28, K=5 wave: pop_o=0, state IDLE, and no pre_wave_done_o afterwards.
REQ-038 W=H=K=1: one single-cycle wave with pop_o[0]=1, then an sa_done_o pulse and no pre_wave_done_o.
- A second start_i during WAVE is ignored.
